// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline register of DEPTH back-to-back stages.
// Each stage carries a valid bit, a control field and a data payload.
// Global stall holds all stages. Per-stage flush turns a stage into a bubble:
// valid and control are cleared, the payload keeps moving.
// occ_o is a registered count of occupied stages.
// Optional feature macro: PIPE_STAGE_BUBBLE_CNT_EN enables a saturating
// 16-bit counter of bubbles leaving the pipe. Without it, bubble_cnt_o is 0.
module pipe_stage_reg #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 111,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic [DEPTH-1:0]  flush_i,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        occ_o,
    output logic [15:0]       bubble_cnt_o
);

    // Reject illegal depths at elaboration time.
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("pipe_stage_reg: DEPTH must be in 1..4");
    end

    logic [DEPTH-1:0]  v_q;
    logic [CTRL_W-1:0] c_q [DEPTH];
    logic [DATA_W-1:0] d_q [DEPTH];
    logic [2:0]        occ_q;

    logic [DEPTH-1:0]  v_d;
    logic [CTRL_W-1:0] c_d [DEPTH];
    logic [DATA_W-1:0] d_d [DEPTH];
    logic [2:0]        occ_d;

    // Next-state of every stage: hold, shift, then apply flush on top.
    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = v_q[k];
            c_d[k] = c_q[k];
            d_d[k] = d_q[k];
        end
        if (!stall_i) begin
            v_d[0] = in_valid;
            c_d[0] = in_valid ? in_ctrl : '0;
            d_d[0] = in_data;
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k] = v_q[k-1];
                c_d[k] = c_q[k-1];
                d_d[k] = d_q[k-1];
            end
        end
        // Flush wins over stall for valid/control. The payload is left alone.
        for (int k = 0; k < DEPTH; k++) begin
            if (flush_i[k]) begin
                v_d[k] = 1'b0;
                c_d[k] = '0;
            end
        end
    end

    // Popcount of the next valid vector, so occ_o moves in step with v.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + {2'b00, v_d[k]};
        end
    end

    // Stage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage arrays are reset explicitly, payload included,
            // because outputs must read all-zero while reset is asserted. A
            // plain storage array would normally be left unreset.
            v_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                c_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments, so every stage samples the
            // pre-edge value of its neighbour regardless of statement order.
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int k = 0; k < DEPTH; k++) begin
                c_q[k] <= c_d[k];
                d_q[k] <= d_d[k];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_ctrl  = c_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign occ_o     = occ_q;

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    logic [15:0] bub_q;

    // Count bubbles leaving the pipe on unstalled edges, saturating at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_q <= '0;
        end else if (!stall_i && !v_q[DEPTH-1] && (bub_q != 16'hFFFF)) begin
            bub_q <= bub_q + 16'd1;
        end
    end

    assign bubble_cnt_o = bub_q;
`else
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. DEPTH=1, 2 and 3 instances share the stimulus.
// Each instance is compared every cycle against a behavioural model of
// its stages. Directed sequences add fixed expected values on top.
module tb_pipe_stage_reg;

    localparam int CW = 9;
    localparam int DW = 111;

    typedef struct packed {
        logic          v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_i = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic [0:0]    flush1 = '0;
    logic [1:0]    flush2 = '0;
    logic [2:0]    flush3 = '0;

    logic          ov  [3];
    logic [CW-1:0] oc  [3];
    logic [DW-1:0] od  [3];
    logic [2:0]    occ [3];
    logic [15:0]   bub [3];

    int n_checks = 0;
    int n_fail   = 0;

    ent_t        mdl  [3][4];
    int unsigned mbub [3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush1),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[0]), .out_ctrl(oc[0]), .out_data(od[0]),
        .occ_o(occ[0]), .bubble_cnt_o(bub[0]));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush2),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[1]), .out_ctrl(oc[1]), .out_data(od[1]),
        .occ_o(occ[1]), .bubble_cnt_o(bub[1]));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush3),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov[2]), .out_ctrl(oc[2]), .out_data(od[2]),
        .occ_o(occ[2]), .bubble_cnt_o(bub[2]));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mbub[i] = 0;
            for (int k = 0; k < 4; k++) mdl[i][k] = '0;
        end
    endtask

    function automatic logic flush_bit(input int i, input int k);
        case (i)
            0:       return flush1[k];
            1:       return flush2[k];
            default: return flush3[k];
        endcase
    endfunction

    // One clock edge of every pipeline, computed from the driven inputs.
    task automatic model_step();
        ent_t incoming;
        ent_t nxt [4];
        incoming.v = in_valid;
        incoming.c = in_valid ? in_ctrl : '0;
        incoming.d = in_data;
        for (int i = 0; i < 3; i++) begin
            int depth = i + 1;
            if (!stall_i && !mdl[i][depth-1].v && mbub[i] < 65535) mbub[i]++;
            for (int k = 0; k < depth; k++) begin
                if (stall_i)     nxt[k] = mdl[i][k];
                else if (k == 0) nxt[k] = incoming;
                else             nxt[k] = mdl[i][k-1];
                if (flush_bit(i, k)) begin
                    nxt[k].v = 1'b0;
                    nxt[k].c = '0;
                end
            end
            for (int k = 0; k < depth; k++) mdl[i][k] = nxt[k];
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            int depth = i + 1;
            int pop = 0;
            int exp_bub;
            ent_t e = mdl[i][depth-1];
            for (int k = 0; k < depth; k++) pop += int'(mdl[i][k].v);
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
            exp_bub = int'(mbub[i]);
`else
            exp_bub = 0;
`endif
            check($sformatf("d%0d_valid", depth), ov[i], e.v);
            check($sformatf("d%0d_ctrl", depth), oc[i], e.c);
            check($sformatf("d%0d_data", depth), od[i], e.d);
            check($sformatf("d%0d_occ", depth), occ[i], pop);
            check($sformatf("d%0d_bubble", depth), bub[i], exp_bub);
        end
    endtask

    task automatic drive(input logic st, input logic iv, input logic [CW-1:0] ic,
                         input logic [DW-1:0] id, input logic [2:0] f);
        stall_i  = st;
        in_valid = iv;
        in_ctrl  = ic;
        in_data  = id;
        flush1   = f[0:0];
        flush2   = f[1:0];
        flush3   = f;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    // Hard bound on simulation time.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, checked before any clock edge.
        drive(1'b0, 1'b0, '0, '0, 3'b000);
        model_clear();
        #3;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // DEPTH=2 latency: one entry, visible exactly two edges later.
        drive(1'b0, 1'b1, 9'h1A5, 111'h5, 3'b000);
        tick();
        check("lat_occ1", occ[1], 3'd1);
        check("lat_v1", ov[1], 1'b0);
        drive(1'b0, 1'b0, 9'h0AA, 111'h0, 3'b000);
        tick();
        check("lat_occ2", occ[1], 3'd1);
        check("lat_v2", ov[1], 1'b1);
        check("lat_ctrl2", oc[1], 9'h1A5);
        check("lat_data2", od[1], 111'h5);
        tick();
        check("lat_occ3", occ[1], 3'd0);
        check("lat_v3", ov[1], 1'b0);

        // DEPTH=1 stall hold, then release.
        drive(1'b0, 1'b1, 9'h0FF, 111'h11, 3'b000);
        tick();
        check("stall_load", oc[0], 9'h0FF);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b1, 9'h001, 111'h22, 3'b000);
            tick();
            check("stall_hold", oc[0], 9'h0FF);
        end
        drive(1'b0, 1'b1, 9'h001, 111'h22, 3'b000);
        tick();
        check("stall_release", oc[0], 9'h001);

        // DEPTH=3 flush of the middle stage under stall.
        drive(1'b0, 1'b1, 9'h0A1, 111'hA, 3'b000); tick();
        drive(1'b0, 1'b1, 9'h0B2, 111'hB, 3'b000); tick();
        drive(1'b0, 1'b1, 9'h0C3, 111'hC, 3'b000); tick();
        check("mid_full_occ", occ[2], 3'd3);
        drive(1'b1, 1'b1, 9'h0D4, 111'hD, 3'b010);
        tick();
        check("mid_flush_occ", occ[2], 3'd2);
        check("mid_flush_out", od[2], 111'hA);
        drive(1'b0, 1'b0, 9'h000, 111'h0, 3'b000);
        tick();
        check("mid_bubble_v", ov[2], 1'b0);
        check("mid_bubble_c", oc[2], 9'h000);
        check("mid_bubble_d", od[2], 111'hB);

        // DEPTH=2 flush of stage 0 while shifting.
        drive(1'b0, 1'b1, 9'h1FF, 111'h7, 3'b000); tick();
        drive(1'b0, 1'b1, 9'h0AA, 111'h8, 3'b001); tick();
        check("f0_out_v", ov[1], 1'b1);
        check("f0_out_c", oc[1], 9'h1FF);
        drive(1'b0, 1'b0, 9'h000, 111'h0, 3'b000); tick();
        check("f0_next_v", ov[1], 1'b0);
        check("f0_next_c", oc[1], 9'h000);
        check("f0_next_d", od[1], 111'h8);

        // All flush bits with stall empties every pipeline.
        drive(1'b0, 1'b1, 9'h033, 111'h33, 3'b000); tick();
        drive(1'b0, 1'b1, 9'h044, 111'h44, 3'b000); tick();
        drive(1'b1, 1'b1, 9'h055, 111'h55, 3'b111); tick();
        for (int i = 0; i < 3; i++) check("flush_all_occ", occ[i], 3'd0);

        // Asynchronous reset between edges with DEPTH=2 holding two entries.
        drive(1'b0, 1'b1, 9'h066, 111'h66, 3'b000); tick();
        drive(1'b0, 1'b1, 9'h077, 111'h77, 3'b000); tick();
        check("areset_pre_occ", occ[1], 3'd2);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("areset_v", ov[1], 1'b0);
        check("areset_c", oc[1], 9'h000);
        check("areset_occ", occ[1], 3'd0);
        compare_all();
        tick();
        rst_n = 1'b1;
        // First edge after release loads normally.
        drive(1'b0, 1'b1, 9'h088, 111'h88, 3'b000);
        tick();
        check("post_reset_load", oc[0], 9'h088);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] f;
            f = '0;
            for (int k = 0; k < 3; k++) f[k] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) f = 3'b111;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                  CW'($urandom), rand_data(), f);
            tick();
        end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        // Long idle run drives the bubble counters into saturation.
        drive(1'b0, 1'b0, '0, '0, 3'b000);
        repeat (70000) begin
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        compare_all();
        check("bub_saturated", bub[0], 16'hFFFF);
        drive(1'b1, 1'b0, '0, '0, 3'b000);
        tick();
        check("bub_stall_hold", bub[0], 16'hFFFF);
        drive(1'b0, 1'b0, '0, '0, 3'b000);
        tick();
        check("bub_no_wrap", bub[0], 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register that replaces the hand-written per-boundary stage registers (ID/EX style).
- Carries a control field, a data payload and a valid bit through DEPTH back-to-back register stages.
- Supports global stall, per-stage flush (bubble insertion) and a live count of occupied stages.
- Instantiated between decode/execute, execute/memory and memory/writeback; hazard unit drives stall/flush.

Parameters:
- CTRL_W, 9, width of control field (RegDst, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite, spare); zeroed on bubble.
- DATA_W, 111, width of payload (rs, rt, rd, immediate, read1, read2); never zeroed by flush.
- DEPTH, 1, number of register stages, legal 1..4; elaboration error outside range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- stall_i  in  1  hold all stages.
- flush_i  in  DEPTH  bit k forces stage k to bubble at next edge.
- in_valid  in  1  incoming entry valid.
- in_ctrl  in  CTRL_W  incoming control.
- in_data  in  DATA_W  incoming payload.
- out_valid  out  1  valid of stage DEPTH-1.
- out_ctrl  out  CTRL_W  control of stage DEPTH-1.
- out_data  out  DATA_W  payload of stage DEPTH-1.
- occ_o  out  3  number of stages with valid=1 (0..DEPTH).
- bubble_cnt_o  out  16  bubble counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async): all stage valid=0, ctrl=0, data=0; occ_o=0; bubble_cnt_o=0. Outputs take reset values immediately, not at next edge.
- Stage k, k=0..DEPTH-1, has registers v[k], c[k], d[k]. Outputs are driven straight from stage DEPTH-1, with no combinational path from inputs.
- Latency: DEPTH cycles from input to output when not stalled.
- Normal edge (stall_i=0):
  - stage 0 loads in_valid/in_ctrl/in_data.
  - stage k>0 loads stage k-1.
- Stall edge (stall_i=1): every stage holds v, c and d.
- Flush: if flush_i[k]=1, stage k gets v=0, c=0 at this edge. Flush has priority over stall.
  - d[k] takes the value it would otherwise have taken: held if stalled, shifted if not.
- Flushing stage k does not affect stage k+1 at the same edge. Stage k+1 receives the pre-edge contents of stage k.
- Bubble definition: v=0 implies c=0 in every stage at all times. Invalid in_valid=0 entries load c=0 regardless of in_ctrl.
- occ_o: registered count of v[] after each edge. It equals the popcount of v at all times and is updated in the same edge as v.
- Simultaneous in_valid=1, stall_i=1: input is dropped. The upstream stage must hold its own register; no backpressure output is provided.
- All flush_i bits set together with stall_i: pipeline empties, occ_o=0 next cycle.
- DEPTH=1: behaves as a single ID/EX register with valid bit and synchronous flush.
- Reset deasserted mid-stream: first edge after release loads normally. No warm-up cycle.

Optional Feature:
- Macro: PIPE_STAGE_BUBBLE_CNT_EN.
- Defined: bubble_cnt_o is a 16-bit counter.
  - Increments on each edge where stall_i=0 and out_valid=0 (bubble leaving the pipe).
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by reset.
- Undefined: no counter logic; bubble_cnt_o tied to 0. Port list is unchanged.

Test Plan:
- DEPTH=2, reset then in_valid=1, in_ctrl=9'h1A5, in_data=111'h5 for 1 cycle, then in_valid=0 -> out_valid=1, out_ctrl=1A5, out_data=5 exactly 2 cycles later for one cycle; occ_o sequence 1,1,0.
- DEPTH=1, in_ctrl=9'h0FF valid, stall_i=1 for 3 cycles with in_ctrl changing to 9'h001 -> out_ctrl stays 0FF for all 3 cycles, becomes 001 on first unstalled edge.
- DEPTH=3, stages filled with valid entries, flush_i=3'b010 with stall_i=1 -> stage 1 v=0, c=0, d unchanged; stages 0 and 2 hold; occ_o 3 -> 2.
- DEPTH=2, flush_i=2'b01 with stall_i=0, stage 0 holding ctrl 9'h1FF -> stage 1 receives 1FF valid, stage 0 becomes bubble; out_valid=1 next cycle, 0 the cycle after.
- Assert rst_n=0 between clock edges with occ_o=2 -> out_valid=0, out_ctrl=0, occ_o=0 before the next rising edge.
- PIPE_STAGE_BUBBLE_CNT_EN defined, DEPTH=1, in_valid=0, stall_i=0 for 70000 cycles -> bubble_cnt_o=16'hFFFF and holds; one stalled cycle does not change it.
